// File: rtl/uc_pipe.sv
// rtl/uc_pipe.sv - EV22 pipeline control shift register (stages 2-5) with stall watchdog.
// Optional UC_PIPE_PERF_EN adds saturating STALL_CNT / RETIRE_CNT outputs.
module uc_pipe #(
    parameter int TYPE_W     = 7,
    parameter int SELA_W     = 5,
    parameter int SEL_W      = 6,
    parameter int HOLD_LIMIT = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [TYPE_W-1:0] Type1,
    input  logic [SELA_W-1:0] SelA1,
    input  logic [SEL_W-1:0]  SelB1,
    input  logic [SEL_W-1:0]  SelC1,
    input  logic              HOLD,
    input  logic              FLUSH,
    output logic              FETCH_EN,
    output logic [TYPE_W-1:0] Type2,
    output logic [SELA_W-1:0] SelA2,
    output logic [SEL_W-1:0]  SelB2,
    output logic [SEL_W-1:0]  SelC2,
    output logic [TYPE_W-1:0] Type3,
    output logic [SEL_W-1:0]  SelC3,
    output logic [TYPE_W-1:0] Type4,
    output logic [SEL_W-1:0]  SelC4,
    output logic [TYPE_W-1:0] Type5,
    output logic [SEL_W-1:0]  SelC5,
`ifdef UC_PIPE_PERF_EN
    output logic [15:0]       STALL_CNT,
    output logic [15:0]       RETIRE_CNT,
`endif
    output logic              HOLD_ERR
);

    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(HOLD_LIMIT);

    logic [TYPE_W-1:0] type2_q, type2_d, type3_q, type3_d;
    logic [TYPE_W-1:0] type4_q, type4_d, type5_q, type5_d;
    logic [SELA_W-1:0] sela2_q, sela2_d;
    logic [SEL_W-1:0]  selb2_q, selb2_d, selc2_q, selc2_d;
    logic [SEL_W-1:0]  selc3_q, selc3_d, selc4_q, selc4_d, selc5_q, selc5_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              hold_err_q, hold_err_d;

    always_comb begin
        type5_d = type4_q;
        selc5_d = selc4_q;
        type4_d = type3_q;
        selc4_d = selc3_q;
        type3_d = '0;
        selc3_d = '0;
        type2_d = type2_q;
        sela2_d = sela2_q;
        selb2_d = selb2_q;
        selc2_d = selc2_q;
        if (!HOLD) begin
            type3_d = type2_q;
            selc3_d = selc2_q;
            type2_d = Type1;
            sela2_d = SelA1;
            selb2_d = SelB1;
            selc2_d = SelC1;
        end
        // A taken jump kills stage 2 even while it is being held.
        if (FLUSH) begin
            type2_d = '0;
            sela2_d = '0;
            selb2_d = '0;
            selc2_d = '0;
        end
    end

    always_comb begin
        hold_cnt_d = '0;
        hold_err_d = hold_err_q;
        if (HOLD) begin
            hold_cnt_d = (hold_cnt_q == LIMIT_C) ? hold_cnt_q : hold_cnt_q + 1'b1;
            if (hold_cnt_d == LIMIT_C) begin
                hold_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            type2_q    <= '0;
            sela2_q    <= '0;
            selb2_q    <= '0;
            selc2_q    <= '0;
            type3_q    <= '0;
            selc3_q    <= '0;
            type4_q    <= '0;
            selc4_q    <= '0;
            type5_q    <= '0;
            selc5_q    <= '0;
            hold_cnt_q <= '0;
            hold_err_q <= 1'b0;
        end else begin
            type2_q    <= type2_d;
            sela2_q    <= sela2_d;
            selb2_q    <= selb2_d;
            selc2_q    <= selc2_d;
            type3_q    <= type3_d;
            selc3_q    <= selc3_d;
            type4_q    <= type4_d;
            selc4_q    <= selc4_d;
            type5_q    <= type5_d;
            selc5_q    <= selc5_d;
            hold_cnt_q <= hold_cnt_d;
            hold_err_q <= hold_err_d;
        end
    end

`ifdef UC_PIPE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, retire_cnt_q, retire_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (HOLD && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (type5_q != '0 && retire_cnt_q != 16'hFFFF) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign STALL_CNT  = stall_cnt_q;
    assign RETIRE_CNT = retire_cnt_q;
`endif

    assign FETCH_EN = ~HOLD & ~nreset;
    assign Type2    = type2_q;
    assign SelA2    = sela2_q;
    assign SelB2    = selb2_q;
    assign SelC2    = selc2_q;
    assign Type3    = type3_q;
    assign SelC3    = selc3_q;
    assign Type4    = type4_q;
    assign SelC4    = selc4_q;
    assign Type5    = type5_q;
    assign SelC5    = selc5_q;
    assign HOLD_ERR = hold_err_q;

endmodule

// File: tb/tb_uc_pipe.sv
// tb/tb_uc_pipe.sv - self-checking bench for uc_pipe: directed cases plus in-order retirement scoreboard.
module tb_uc_pipe;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic [6:0] Type1 = '0;
    logic [4:0] SelA1 = '0;
    logic [5:0] SelB1 = '0;
    logic [5:0] SelC1 = '0;
    logic       HOLD = 1'b0;
    logic       FLUSH = 1'b0;
    logic       FETCH_EN, HOLD_ERR;
    logic [6:0] Type2, Type3, Type4, Type5;
    logic [4:0] SelA2;
    logic [5:0] SelB2, SelC2, SelC3, SelC4, SelC5;
`ifdef UC_PIPE_PERF_EN
    logic [15:0] STALL_CNT, RETIRE_CNT;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0] t;
        logic [5:0] c;
    } instr_t;
    instr_t sb_q[$];
    logic   s2_valid;

    uc_pipe #(.TYPE_W(7), .SELA_W(5), .SEL_W(6), .HOLD_LIMIT(8)) dut (
        .clk(clk), .nreset(nreset),
        .Type1(Type1), .SelA1(SelA1), .SelB1(SelB1), .SelC1(SelC1),
        .HOLD(HOLD), .FLUSH(FLUSH), .FETCH_EN(FETCH_EN),
        .Type2(Type2), .SelA2(SelA2), .SelB2(SelB2), .SelC2(SelC2),
        .Type3(Type3), .SelC3(SelC3), .Type4(Type4), .SelC4(SelC4),
        .Type5(Type5), .SelC5(SelC5),
`ifdef UC_PIPE_PERF_EN
        .STALL_CNT(STALL_CNT), .RETIRE_CNT(RETIRE_CNT),
`endif
        .HOLD_ERR(HOLD_ERR)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] t, input logic [5:0] c, input logic h, input logic f);
        Type1 = t;
        SelA1 = t[4:0] ^ 5'h15;
        SelB1 = c ^ 6'h2A;
        SelC1 = c;
        HOLD  = h;
        FLUSH = f;
    endtask

    function automatic logic all_zero();
        return ({Type2, SelA2, SelB2, SelC2, Type3, SelC3, Type4, SelC4, Type5, SelC5} == '0);
    endfunction

    task automatic do_reset();
        #2 nreset = 1'b1;
        #1;
        check_val("rst_stages_zero", {31'd0, all_zero()}, 32'd1);
        check_val("rst_fetch_en", {31'd0, FETCH_EN}, 32'd0);
        check_val("rst_hold_err", {31'd0, HOLD_ERR}, 32'd0);
        drive('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        nreset = 1'b0;
        #1;
    endtask

    initial begin
        // Power-on reset.
        #3;
        do_reset();
        check_val("fetch_en_run", {31'd0, FETCH_EN}, 32'd1);

        // Free flow: one instruction walks stages 2..5.
        drive(7'h04, 6'h0A, 1'b0, 1'b0);
        step();
        check_val("ff_type2", {25'd0, Type2}, 32'h04);
        check_val("ff_sela2", {27'd0, SelA2}, 32'h11);
        check_val("ff_selb2", {26'd0, SelB2}, 32'h20);
        check_val("ff_selc2", {26'd0, SelC2}, 32'h0A);
        drive('0, '0, 1'b0, 1'b0);
        step();
        check_val("ff_type3", {25'd0, Type3}, 32'h04);
        check_val("ff_type2_bub", {25'd0, Type2}, 32'h00);
        step();
        check_val("ff_type4", {25'd0, Type4}, 32'h04);
        step();
        check_val("ff_type5", {25'd0, Type5}, 32'h04);
        check_val("ff_selc5", {26'd0, SelC5}, 32'h0A);

        // Single stall: X held in stage 2, bubble injected into stage 3.
        drive(7'h02, 6'h11, 1'b0, 1'b0);
        step();
        drive(7'h08, 6'h12, 1'b1, 1'b0);
        #1;
        check_val("stall_fetch_en", {31'd0, FETCH_EN}, 32'd0);
        step();
        check_val("stall_type3_bub", {25'd0, Type3}, 32'h00);
        check_val("stall_type2_x", {25'd0, Type2}, 32'h02);
        check_val("stall_selc2_x", {26'd0, SelC2}, 32'h11);
        drive(7'h08, 6'h12, 1'b0, 1'b0);
        step();
        check_val("stall_type3_x", {25'd0, Type3}, 32'h02);
        check_val("stall_type2_y", {25'd0, Type2}, 32'h08);

        // Hold + flush: stages 2 and 3 both bubble, stage 4 takes old stage 3.
        drive(7'h10, 6'h13, 1'b1, 1'b1);
        step();
        check_val("hf_type2", {25'd0, Type2}, 32'h00);
        check_val("hf_selc2", {26'd0, SelC2}, 32'h00);
        check_val("hf_type3", {25'd0, Type3}, 32'h00);
        check_val("hf_type4", {25'd0, Type4}, 32'h02);
        check_val("hf_selc4", {26'd0, SelC4}, 32'h11);

        // Mid-stream asynchronous reset with every stage occupied.
        for (int i = 0; i < 4; i++) begin
            drive(7'h40 >> i, 6'(i + 1), 1'b0, 1'b0);
            step();
        end
        check_val("mid_full", {31'd0, all_zero()}, 32'd0);
        do_reset();

        // Deadlock watchdog.
        drive('0, '0, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_val($sformatf("dl_err_e%0d", k), {31'd0, HOLD_ERR}, (k == 8) ? 32'd1 : 32'd0);
        end
        drive('0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step();
        check_val("dl_sticky", {31'd0, HOLD_ERR}, 32'd1);
        do_reset();

        // Random stream; retirements compared in order against the scoreboard.
        s2_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [6:0] t;
            logic [5:0] c;
            logic       h, f;
            t = 7'($urandom_range(1, 127));
            c = 6'($urandom);
            h = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            if (n >= 395) begin
                t = '0;
                h = 1'b0;
                f = 1'b0;
            end
            drive(t, c, h, f);
            if (!h) begin
                s2_valid = 1'b0;
                if (!f && t != '0) begin
                    sb_q.push_back('{t: t, c: c});
                    s2_valid = 1'b1;
                end
            end else if (f && s2_valid) begin
                void'(sb_q.pop_back());
                s2_valid = 1'b0;
            end
            step();
            if (Type5 != '0) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected", {25'd0, Type5}, 32'd0);
                end else begin
                    instr_t e;
                    e = sb_q.pop_front();
                    check_val("sb_type5", {25'd0, Type5}, {25'd0, e.t});
                    check_val("sb_selc5", {26'd0, SelC5}, {26'd0, e.c});
                end
            end
        end
        check_val("sb_drained", sb_q.size(), 32'd0);

`ifdef UC_PIPE_PERF_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(7'h01 << i, 6'(i), 1'b0, 1'b0);
            step();
        end
        drive('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        drive('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step();
        check_val("perf_stall", {16'd0, STALL_CNT}, 32'd3);
        check_val("perf_retire", {16'd0, RETIRE_CNT}, 32'd5);
        do_reset();
        drive('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        check_val("perf_stall_sat", {16'd0, STALL_CNT}, 32'hFFFF);
        drive('0, '0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uc_pipe.md
# uc_pipe

Pipeline control shift register of the EV22 core, sitting directly downstream of the stage-2 hazard unit. Captures the decoded control fields (instruction type and register selectors) from stage 1 and shifts them through stages 2–5, producing the Type/SelC signals the hazard unit compares. Consumes the hazard unit's HOLD to freeze fetch and stage 2 and to inject bubbles into stage 3. Also detects stalls that never release.

## Interface
Parameters:
- TYPE_W, 7, one-hot type vector width (bit 0 WR_read, 1 WR_write, 2 R_read, 3 R_write, 4 C_read, 5 C_write, 6 Jump)
- SELA_W, 5, SelA width
- SEL_W, 6, SelB/SelC width
- HOLD_LIMIT, 8, consecutive HOLD cycles tolerated before HOLD_ERR (must be ≥1)

Ports:
- clk  in  1  core clock, rising edge
- nreset  in  1  asynchronous, active-high reset (1 = reset)
- Type1  in  TYPE_W  decoded type of the stage-1 instruction
- SelA1  in  SELA_W  stage-1 A selector
- SelB1  in  SEL_W  stage-1 B selector
- SelC1  in  SEL_W  stage-1 destination selector
- HOLD  in  1  stall request from hazard unit (combinational from stage-2..5 fields)
- FLUSH  in  1  kill the instruction entering stage 2 (taken jump)
- FETCH_EN  out  1  fetch/PC advance enable
- Type2, SelA2, SelB2, SelC2  out  TYPE_W/SELA_W/SEL_W/SEL_W  stage-2 fields
- Type3, SelC3  out  TYPE_W/SEL_W  stage-3 fields
- Type4, SelC4  out  TYPE_W/SEL_W  stage-4 fields
- Type5, SelC5  out  TYPE_W/SEL_W  stage-5 fields
- HOLD_ERR  out  1  sticky stall-deadlock flag

## Operation
- Bubble = Type all zero, all Sel fields zero.
- On each rising clk edge (nreset=0), evaluated in priority order:
  - Stages 4, 5 always shift: 5←4, 4←3.
  - HOLD=0: 3←2; 2←stage-1 fields, or bubble if FLUSH=1.
  - HOLD=1: 3←bubble; 2 holds, or becomes bubble if FLUSH=1 (FLUSH overrides hold).
- FETCH_EN = ~HOLD & ~nreset, combinational.
- Stall counter: increments on each edge with HOLD=1, clears on HOLD=0, saturates at HOLD_LIMIT. HOLD_ERR sets when counter reaches HOLD_LIMIT with HOLD still 1; stays set until reset. HOLD_ERR does not alter pipeline behaviour.
- No arithmetic beyond the counter; counter width = clog2(HOLD_LIMIT+1).

## Timing
- Reset (async, immediate): all stage registers bubble, counter 0, HOLD_ERR 0, FETCH_EN 0.
- First edge after reset release loads stage 2 from stage 1 (HOLD assumed 0 since stages are bubbles).
- Latency: stage-1 fields appear on stage-2 outputs 1 edge after capture, stage 5 after 4 edges with no HOLD.
- Every HOLD cycle adds exactly one bubble in stage 3 and delays the stage-2 instruction by one edge.
- HOLD with all of 3–5 bubbles is permitted; holds stage 2 indefinitely (deadlock → HOLD_ERR after HOLD_LIMIT edges).
- HOLD and FLUSH same cycle: stage 2 and stage 3 both bubble.
- Reset asserted mid-operation: all stages bubble immediately, no partial shift.

## Configuration
- UC_PIPE_PERF_EN defined: adds outputs STALL_CNT (16 bit) and RETIRE_CNT (16 bit). STALL_CNT increments every edge with HOLD=1; RETIRE_CNT increments every edge where Type5 ≠ 0; both saturate at 0xFFFF, reset to 0.
- Not defined: neither port nor counters exist; all other behaviour identical.

## Test plan
- Reset: assert nreset mid-stream with non-zero stages → all Type/Sel outputs 0, FETCH_EN 0, HOLD_ERR 0 immediately.
- Free flow: feed Type1=7'b0000100, SelC1=6'h0A at edge 1, bubbles after, HOLD=0 → Type2/3/4/5 show 7'h04 at edges 1/2/3/4, SelC5=6'h0A at edge 4.
- Single stall: instr X in stage 2, HOLD=1 for one edge → Type3 = 0 after that edge, X stays in stage 2, FETCH_EN=0 during cycle, X reaches stage 3 one edge later.
- Hold+flush: HOLD=1, FLUSH=1 with X in stage 2 → after edge Type2=0, Type3=0, stage 4 = prior stage 3.
- Deadlock: HOLD_LIMIT=8, HOLD tied 1 → HOLD_ERR rises on 8th edge, remains 1 after HOLD drops, clears only on reset.
- UC_PIPE_PERF_EN: 3 stall edges and 5 instructions retired → STALL_CNT=3, RETIRE_CNT=5; force 70000 stalls → STALL_CNT=0xFFFF.
